// File: rtl/fwd_scoreboard_unit_if.sv
// Operand-forwarding bus between rename/register-read, the bypass network and issue.
// Optional FWD_HAZARD_STATS_EN adds the o_stall_cycles observation signal.
interface fwd_scoreboard_unit_if #(
  parameter int PHYS_REGS  = 64,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_RD     = 2,
  parameter int NUM_BYP    = 2,
  parameter int TAG_W      = $clog2(PHYS_REGS)
) ();

  logic                          alloc_valid;
  logic [TAG_W-1:0]              alloc_tag;
  logic                          flush;
  logic                          wb_valid;
  logic [TAG_W-1:0]              wb_tag;
  logic [DATA_WIDTH-1:0]         wb_data;
  logic [NUM_BYP-1:0]            byp_valid;
  logic [NUM_BYP-1:0]            byp_ready;
  logic [NUM_BYP*TAG_W-1:0]      byp_tag;
  logic [NUM_BYP*DATA_WIDTH-1:0] byp_data;
  logic [NUM_RD-1:0]             rd_uses;
  logic [NUM_RD*TAG_W-1:0]       rd_tag;
  logic [NUM_RD*DATA_WIDTH-1:0]  rd_rf_data;
  logic [NUM_RD*DATA_WIDTH-1:0]  rd_data;
  logic [NUM_RD-1:0]             rd_ready;
  logic                          o_hazard;
  logic [TAG_W:0]                o_busy_count;
`ifdef FWD_HAZARD_STATS_EN
  logic [31:0]                   o_stall_cycles;
`endif

  modport master (
    output alloc_valid, alloc_tag, flush,
    output wb_valid, wb_tag, wb_data,
    output byp_valid, byp_ready, byp_tag, byp_data,
    output rd_uses, rd_tag, rd_rf_data,
`ifdef FWD_HAZARD_STATS_EN
    input  o_stall_cycles,
`endif
    input  rd_data, rd_ready, o_hazard, o_busy_count
  );

  modport slave (
    input  alloc_valid, alloc_tag, flush,
    input  wb_valid, wb_tag, wb_data,
    input  byp_valid, byp_ready, byp_tag, byp_data,
    input  rd_uses, rd_tag, rd_rf_data,
`ifdef FWD_HAZARD_STATS_EN
    output o_stall_cycles,
`endif
    output rd_data, rd_ready, o_hazard, o_busy_count
  );

endinterface

// File: rtl/fwd_scoreboard_unit.sv
// Busy-bit scoreboard over physical tags with priority operand forwarding and stall request.
// Define FWD_HAZARD_STATS_EN to add the saturating o_stall_cycles counter.
module fwd_scoreboard_unit #(
  parameter int PHYS_REGS  = 64,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_RD     = 2,
  parameter int NUM_BYP    = 2,
  parameter int TAG_W      = $clog2(PHYS_REGS)
) (
  input logic                clk,
  input logic                rst,
  fwd_scoreboard_unit_if.slave bus
);

  logic [PHYS_REGS-1:0]         busy_q, busy_d;
  logic [TAG_W:0]               count_q, count_d;
  logic                         alloc_set, wb_clr, cnt_inc, cnt_dec;

  logic [NUM_RD*DATA_WIDTH-1:0] fwd_data;
  logic [NUM_RD-1:0]            fwd_ready;
  logic                         hazard;

  // A same-cycle alloc of the write-back tag suppresses the clear so the new producer keeps it busy.
  always_comb begin
    busy_d    = busy_q;
    count_d   = count_q;
    alloc_set = bus.alloc_valid && (bus.alloc_tag != '0);
    wb_clr    = bus.wb_valid && (bus.wb_tag != '0)
                && !(alloc_set && (bus.wb_tag == bus.alloc_tag));
    cnt_inc   = alloc_set && !busy_q[bus.alloc_tag];
    cnt_dec   = wb_clr && busy_q[bus.wb_tag];
    if (bus.flush) begin
      busy_d  = '0;
      count_d = '0;
    end else begin
      if (alloc_set) busy_d[bus.alloc_tag] = 1'b1;
      if (wb_clr)    busy_d[bus.wb_tag]    = 1'b0;
      count_d = count_q + {{TAG_W{1'b0}}, cnt_inc} - {{TAG_W{1'b0}}, cnt_dec};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q  <= '0;
      count_q <= '0;
    end else begin
      busy_q  <= busy_d;
      count_q <= count_d;
    end
  end

  // Youngest matching bypass wins outright, even when not ready, so stale older data never leaks through.
  always_comb begin
    logic             hit;
    logic [TAG_W-1:0] tag;
    fwd_data  = bus.rd_rf_data;
    fwd_ready = '1;
    hazard    = 1'b0;
    for (int unsigned i = 0; i < NUM_RD; i++) begin
      hit = 1'b0;
      tag = bus.rd_tag[i*TAG_W +: TAG_W];
      if (bus.rd_uses[i] && (tag != '0)) begin
        for (int unsigned k = 0; k < NUM_BYP; k++) begin
          if (!hit && bus.byp_valid[k] && (bus.byp_tag[k*TAG_W +: TAG_W] == tag)) begin
            hit                              = 1'b1;
            fwd_data[i*DATA_WIDTH +: DATA_WIDTH] = bus.byp_data[k*DATA_WIDTH +: DATA_WIDTH];
            fwd_ready[i]                     = bus.byp_ready[k];
          end
        end
        if (!hit) begin
          if (bus.wb_valid && (bus.wb_tag == tag)) begin
            fwd_data[i*DATA_WIDTH +: DATA_WIDTH] = bus.wb_data;
            fwd_ready[i]                     = 1'b1;
          end else begin
            fwd_ready[i] = ~busy_q[tag];
          end
        end
      end
      hazard = hazard | (bus.rd_uses[i] & ~fwd_ready[i]);
    end
  end

  assign bus.rd_data      = fwd_data;
  assign bus.rd_ready     = fwd_ready;
  assign bus.o_hazard     = hazard;
  assign bus.o_busy_count = count_q;

`ifdef FWD_HAZARD_STATS_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
    end else if (hazard && (stall_q != '1)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign bus.o_stall_cycles = stall_q;
`endif

endmodule
